dlsc_axi_router_command: RTL

Front end of an AXI router address path (AW or AR). Round-robin arbitrates address requests from SOURCES masters and decodes each winning address to a sink index. Forwards the address beat to the selected sink. Issues the matching cmd_push/cmd_source/cmd_sink into the router data channel's command port, honouring cmd_full. One instance per address channel; it is the sole pusher of its channel's command interface.

---
 rtl/dlsc_axi_router_command_pkg.sv | 40 ++++
 rtl/dlsc_axi_router_command_if.sv | 43 ++++
 rtl/dlsc_axi_router_rr_arbiter.sv | 42 ++++
 rtl/dlsc_axi_router_command.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dlsc_axi_router_command_pkg.sv
// Shared definitions for the AXI router address-path front end: FSM encoding,
// index-width helper and sink region decode helpers.
package dlsc_axi_router_command_pkg;

    // Widest address and widest packed region vector the helpers handle.
    localparam int unsigned MaxAddr   = 64;
    localparam int unsigned MaxPacked = 1024;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } cmd_state_e;

    // Bits needed to index n items, never less than 1.
    function automatic int unsigned log2_min1(input int unsigned n);
        int unsigned b;
        b = 1;
        while ((32'd1 << b) < n) b++;
        return b;
    endfunction

    // Extract word k of width w from a packed region vector (word k at [k*w +: w]).
    function automatic logic [MaxAddr-1:0] region_slice(input logic [MaxPacked-1:0] vec,
                                                        input int unsigned k,
                                                        input int unsigned w);
        logic [MaxPacked-1:0] s;
        logic [MaxAddr-1:0]   m;
        s = vec >> (k * w);
        m = {MaxAddr{1'b1}} >> (MaxAddr - w);
        return s[MaxAddr-1:0] & m;
    endfunction

    // Masked compare of an address against one region.
    function automatic logic region_hit(input logic [MaxAddr-1:0] addr,
                                        input logic [MaxAddr-1:0] base,
                                        input logic [MaxAddr-1:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/dlsc_axi_router_command_if.sv
// Address-channel bundle between masters, sinks and the data-channel command port.
interface dlsc_axi_router_command_if #(
    parameter int unsigned ADDR     = 32,
    parameter int unsigned LEN      = 8,
    parameter int unsigned SOURCES  = 1,
    parameter int unsigned SOURCESB = 1,
    parameter int unsigned SINKS    = 1,
    parameter int unsigned SINKSB   = 1
);
    logic [SOURCES-1:0]      source_ready;
    logic [SOURCES-1:0]      source_valid;
    logic [SOURCES*ADDR-1:0] source_addr;
    logic [SOURCES*LEN-1:0]  source_len;
    logic [SINKS-1:0]        sink_ready;
    logic [SINKS-1:0]        sink_valid;
    logic [ADDR-1:0]         sink_addr;
    logic [LEN-1:0]          sink_len;
    logic [SOURCESB-1:0]     sink_source;
    logic                    cmd_full;
    logic                    cmd_push;
    logic [SOURCESB-1:0]     cmd_source;
    logic [SINKSB-1:0]       cmd_sink;

    // Router side.
    modport master (
        output source_ready,
        input  source_valid, source_addr, source_len,
        input  sink_ready,
        output sink_valid, sink_addr, sink_len, sink_source,
        input  cmd_full,
        output cmd_push, cmd_source, cmd_sink
    );

    // Environment side (masters, sinks, data channel).
    modport slave (
        input  source_ready,
        output source_valid, source_addr, source_len,
        output sink_ready,
        input  sink_valid, sink_addr, sink_len, sink_source,
        output cmd_full,
        input  cmd_push, cmd_source, cmd_sink
    );
endinterface

// File: rtl/dlsc_axi_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last winner, with wrap.
module dlsc_axi_router_rr_arbiter #(
    parameter int unsigned N  = 1,
    parameter int unsigned NB = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          update,
    output logic [N-1:0]  grant,
    output logic [NB-1:0] grant_idx
);

    logic [NB-1:0] ptr_q;

    // Search offsets 1..N from the pointer; first requesting slot wins.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (32'(ptr_q) + i) % N)) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = j[NB-1:0];
                end
            end
        end
    end

    // Pointer tracks the last winner; reset value makes slot 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= NB'(N - 1);
        end else if (update) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/dlsc_axi_router_command.sv
// AXI router address-path front end: arbitrates masters, decodes the sink,
// forwards the address beat and pushes the matching data-channel command.
module dlsc_axi_router_command
    import dlsc_axi_router_command_pkg::*;
#(
    parameter int unsigned           ADDR         = 32,
    parameter int unsigned           LEN          = 8,
    parameter int unsigned           SOURCES      = 1,
    parameter int unsigned           SOURCESB     = log2_min1(SOURCES),
    parameter int unsigned           SINKS        = 1,
    parameter int unsigned           SINKSB       = log2_min1(SINKS),
    parameter logic [SINKS*ADDR-1:0] SINK_BASE    = '0,
    parameter logic [SINKS*ADDR-1:0] SINK_MASK    = '0,
    parameter int unsigned           DEFAULT_SINK = 0
) (
    input logic                       clk,
    input logic                       rst_n,
    dlsc_axi_router_command_if.master bus
);

    cmd_state_e          state_q;
    logic [ADDR-1:0]     addr_q;
    logic [LEN-1:0]      len_q;
    logic [SOURCESB-1:0] src_q;
    logic [SINKSB-1:0]   sink_q;

    logic [SOURCES-1:0]  grant;
    logic [SOURCESB-1:0] grant_idx;
    logic                grant_en;
    logic [ADDR-1:0]     grant_addr;
    logic [LEN-1:0]      grant_len;
    logic [SINKSB-1:0]   dec_sink;
    logic                issue_ok;

    // rst_n gates the grant so a beat is never accepted while state is held in reset.
    assign grant_en = rst_n && (state_q == StIdle) && (|bus.source_valid);

    dlsc_axi_router_rr_arbiter #(
        .N  (SOURCES),
        .NB (SOURCESB)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.source_valid),
        .update    (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.source_ready = grant_en ? grant : '0;

    // Select the winning master's address and length.
    always_comb begin
        grant_addr = '0;
        grant_len  = '0;
        for (int unsigned i = 0; i < SOURCES; i++) begin
            if (grant[i]) begin
                grant_addr = bus.source_addr[i*ADDR +: ADDR];
                grant_len  = bus.source_len[i*LEN +: LEN];
            end
        end
    end

    // Region decode: lowest matching sink wins, otherwise the default sink.
    always_comb begin
        logic found;
        found    = 1'b0;
        dec_sink = SINKSB'(DEFAULT_SINK);
        for (int unsigned k = 0; k < SINKS; k++) begin
            if (!found && region_hit(MaxAddr'(grant_addr),
                                     region_slice(MaxPacked'(SINK_BASE), k, ADDR),
                                     region_slice(MaxPacked'(SINK_MASK), k, ADDR))) begin
                found    = 1'b1;
                dec_sink = SINKSB'(k);
            end
        end
    end

    // Valid is withheld while the command queue is full so push and beat stay paired.
    assign issue_ok = (state_q == StIssue) && !bus.cmd_full;

    // One-hot valid toward the selected sink.
    always_comb begin
        bus.sink_valid = '0;
        for (int unsigned k = 0; k < SINKS; k++) begin
            bus.sink_valid[k] = issue_ok && (32'(sink_q) == k);
        end
    end

    assign bus.cmd_push    = |(bus.sink_valid & bus.sink_ready);
    assign bus.sink_addr   = addr_q;
    assign bus.sink_len    = len_q;
    assign bus.sink_source = src_q;
    assign bus.cmd_source  = src_q;
    assign bus.cmd_sink    = sink_q;

    // Transaction FSM: capture on grant, release on the sink handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            src_q   <= '0;
            sink_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_en) begin
                        addr_q  <= grant_addr;
                        len_q   <= grant_len;
                        src_q   <= grant_idx;
                        sink_q  <= dec_sink;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.cmd_push) state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
